// File: rtl/ifu_fetch_unit.sv
// Instruction fetch stage: owns the PC, fetches over a req/ack memory handshake,
// holds the instruction for the datapath and selects the next PC on retirement.
module ifu_fetch_unit #(
    parameter logic [31:0] PC_RESET = 32'h0000_3000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [2:0]  Npc_op,
    input  logic        br_taken,
    input  logic [31:0] jr_target,
    input  logic        advance,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic [31:0] Instruction,
    output logic        instr_valid,
    output logic [31:0] pc,
    output logic [31:0] pc_plus4,
    output logic        misalign_err
);

    localparam logic [1:0] S_FETCH = 2'd0;
    localparam logic [1:0] S_WAIT  = 2'd1;
    localparam logic [1:0] S_VALID = 2'd2;
    localparam logic [1:0] S_ERROR = 2'd3;

    localparam logic [2:0] OP_BRANCH = 3'b001;
    localparam logic [2:0] OP_JUMP   = 3'b010;
    localparam logic [2:0] OP_JR     = 3'b011;

    logic [1:0]  state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] instr_q, instr_d;
    logic        err_q, err_d;
    // armed_q keeps the request low until the first edge after reset release,
    // so a stale ack arriving in that window cannot be mistaken for a response.
    logic        armed_q, armed_d;

    logic [31:0] seq_pc;
    logic [31:0] branch_off;
    logic [31:0] npc;
    logic        jr_misalign;

    assign seq_pc     = pc_q + 32'd4;
    assign branch_off = {{14{instr_q[15]}}, instr_q[15:0], 2'b00};

    always_comb begin
        npc = seq_pc;
        case (Npc_op)
            OP_BRANCH: npc = br_taken ? (seq_pc + branch_off) : seq_pc;
            OP_JUMP:   npc = {seq_pc[31:28], instr_q[25:0], 2'b00};
            OP_JR:     npc = jr_target;
            default:   npc = seq_pc;
        endcase
    end

    assign jr_misalign = (Npc_op == OP_JR) && (jr_target[1:0] != 2'b00);

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        instr_d = instr_q;
        err_d   = err_q;
        armed_d = 1'b1;
        case (state_q)
            S_FETCH: begin
                if (armed_q) begin
                    if (imem_ack) begin
                        instr_d = imem_rdata;
                        state_d = S_VALID;
                    end else begin
                        state_d = S_WAIT;
                    end
                end
            end
            S_WAIT: begin
                if (imem_ack) begin
                    instr_d = imem_rdata;
                    state_d = S_VALID;
                end
            end
            S_VALID: begin
                if (advance) begin
                    // A misaligned jr target leaves pc on the offending instruction.
                    if (jr_misalign) begin
                        err_d   = 1'b1;
                        state_d = S_ERROR;
                    end else begin
                        pc_d    = npc;
                        state_d = S_FETCH;
                    end
                end
            end
            default: state_d = S_ERROR;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_FETCH;
            pc_q    <= PC_RESET;
            instr_q <= 32'd0;
            err_q   <= 1'b0;
            armed_q <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            instr_q <= instr_d;
            err_q   <= err_d;
            armed_q <= armed_d;
        end
    end

    assign imem_req     = armed_q && ((state_q == S_FETCH) || (state_q == S_WAIT));
    assign imem_addr    = pc_q;
    assign Instruction  = instr_q;
    assign instr_valid  = (state_q == S_VALID);
    assign pc           = pc_q;
    assign pc_plus4     = seq_pc;
    assign misalign_err = err_q;

endmodule
